// File: rtl/sync_fifo_param.sv
// ============================================================================
// sync_fifo_param
// ----------------------------------------------------------------------------
// Synchronous FIFO for buffering pixel/command words between the bus side and
// the processing pipelines. It provides an exact fill count, programmable
// almost-full/almost-empty thresholds, a synchronous flush and a selectable
// read mode (registered read or first-word-fall-through).
//
// Parameters:
//   DATA_WIDTH   - width of each stored word in bits
//   ADDR_WIDTH   - log2 of the depth; DEPTH = 2**ADDR_WIDTH (1..12)
//   AFULL_LEVEL  - almost_full asserts when count >= AFULL_LEVEL (1..DEPTH)
//   AEMPTY_LEVEL - almost_empty asserts when count <= AEMPTY_LEVEL (0..DEPTH-1)
//   FWFT         - 0: registered read (1-cycle latency), 1: first-word-fall-through
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous reset, active low
//   flush        in   synchronous clear of contents (beats wr_en and rd_en)
//   wr_en        in   write request
//   wr_data      in   write word
//   rd_en        in   read request (FWFT=1: acknowledge of the head word)
//   rd_data      out  read word
//   rd_valid     out  rd_data holds a valid word
//   full         out  DEPTH entries stored
//   empty        out  zero entries stored
//   almost_full  out  count >= AFULL_LEVEL
//   almost_empty out  count <= AEMPTY_LEVEL
//   count        out  number of stored entries, 0..DEPTH
//
// Optional feature, enabled by defining the macro SYNC_FIFO_ERR_FLAGS_EN:
//   err_clr      in   synchronous clear of both error flags (beats a new set)
//   overflow     out  sticky, set after a write is attempted while full
//   underflow    out  sticky, set after a read is attempted while empty
// Without the macro these ports do not exist and dropped requests are silent.
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH   = 17,
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_LEVEL  = 6,
    parameter int AEMPTY_LEVEL = 1,
    parameter int FWFT         = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Thresholds resized once to the count width so the comparisons below
    // are width-matched.
    localparam logic [ADDR_WIDTH:0] AFULL_THR  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_THR = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

    // ------------------------------------------------------------------------
    // Storage and pointers
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // One extra MSB on each pointer acts as a wrap bit: equal pointers mean
    // empty, equal addresses with differing wrap bits mean full.
    logic [ADDR_WIDTH:0]   wrPtr;
    logic [ADDR_WIDTH:0]   rdPtr;

    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [ADDR_WIDTH-1:0] rdAddr;
    logic                  wrAcc;
    logic                  rdAcc;

    assign wrAddr = wrPtr[ADDR_WIDTH-1:0];
    assign rdAddr = rdPtr[ADDR_WIDTH-1:0];

    // ------------------------------------------------------------------------
    // Status flags: purely functions of the registered pointers, so they
    // change only in the cycle after the edge that accepted a request.
    // ------------------------------------------------------------------------
    assign empty        = (wrPtr == rdPtr);
    assign full         = (wrAddr == rdAddr) && (wrPtr[ADDR_WIDTH] != rdPtr[ADDR_WIDTH]);
    assign count        = wrPtr - rdPtr;      // modulo 2**(ADDR_WIDTH+1)
    assign almost_full  = (count >= AFULL_THR);
    assign almost_empty = (count <= AEMPTY_THR);

    // Flush blocks both accepts, so a flush cycle never moves data.
    assign wrAcc = wr_en & ~full  & ~flush;
    assign rdAcc = rd_en & ~empty & ~flush;

    // ------------------------------------------------------------------------
    // Pointer registers
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wrAcc) wrPtr <= wrPtr + 1'b1;
            if (rdAcc) rdPtr <= rdPtr + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Memory write port
    // ------------------------------------------------------------------------
    // NOTE: the array deliberately has no reset; a reset would turn it into
    // DEPTH*DATA_WIDTH resettable flops instead of a plain RAM, and the
    // pointers already make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wrAcc) mem[wrAddr] <= wr_data;
    end

    // ------------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented continuously; rd_en only pops it. The
            // word is stale while empty, which rd_valid=0 covers.
            assign rd_data  = mem[rdAddr];
            assign rd_valid = ~empty;
        end else begin : g_registered
            // rd_data keeps its last value when no read is accepted,
            // including across a flush.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rdAcc;
                    if (rdAcc) rd_data <= mem[rdAddr];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Optional sticky error flags
    // ------------------------------------------------------------------------
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflowEvt;
    logic underflowEvt;

    assign overflowEvt  = wr_en & full  & ~flush;
    assign underflowEvt = rd_en & empty & ~flush;

    // err_clr wins over a same-cycle event; flush leaves the flags alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (err_clr) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (overflowEvt)  overflow  <= 1'b1;
            if (underflowEvt) underflow <= 1'b1;
        end
    end
`else
    // Error tracking not built: dropped writes and ignored reads leave no trace.
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// tb_sync_fifo_param
// ----------------------------------------------------------------------------
// Self-checking bench for sync_fifo_param. Two instances share one stimulus
// stream: dutReg (FWFT=0) and dutFwft (FWFT=1). Both are compared against a
// queue-based reference model. Define SYNC_FIFO_ERR_FLAGS_EN to also cover the
// overflow/underflow flags.
// ============================================================================
module tb_sync_fifo_param;

    localparam int DW    = 17;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 1;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          flush   = 1'b0;
    logic          wr_en   = 1'b0;
    logic          rd_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0] rdData0, rdData1;
    logic          rdValid0, rdValid1;
    logic          full0, full1, empty0, empty1;
    logic          af0, af1, ae0, ae1;
    logic [AW:0]   count0, count1;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          errClr = 1'b0;
    logic          ovf0, ovf1, unf0, unf1;
`endif

    int chkCnt = 0;
    int errCnt = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic [DW-1:0] expRdData  = '0;
    logic          expRdValid = 1'b0;
    logic          expOvf     = 1'b0;
    logic          expUnf     = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(AFL),
                      .AEMPTY_LEVEL(AEL), .FWFT(0)) dutReg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rdData0), .rd_valid(rdValid0), .full(full0),
        .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(count0)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr(errClr), .overflow(ovf0), .underflow(unf0)
`endif
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(AFL),
                      .AEMPTY_LEVEL(AEL), .FWFT(1)) dutFwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rdData1), .rd_valid(rdValid1), .full(full1),
        .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(count1)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .err_clr(errClr), .overflow(ovf1), .underflow(unf1)
`endif
    );

    // Packed status {count, full, empty, almost_full, almost_empty, rd_valid}
    wire [8:0] obsStat0 = {count0, full0, empty0, af0, ae0, rdValid0};
    wire [8:0] obsStat1 = {count1, full1, empty1, af1, ae1, rdValid1};

    function automatic logic [8:0] expStat0();
        int n;
        n = q.size();
        return {4'(n), n == DEPTH, n == 0, n >= AFL, n <= AEL, expRdValid};
    endfunction

    function automatic logic [8:0] expStat1();
        int n;
        n = q.size();
        return {4'(n), n == DEPTH, n == 0, n >= AFL, n <= AEL, n != 0};
    endfunction

    function automatic logic [DW-1:0] expHead();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    task automatic modelReset();
        q.delete();
        expRdData  = '0;
        expRdValid = 1'b0;
        expOvf     = 1'b0;
        expUnf     = 1'b0;
    endtask

    // Applies the FIFO rules to the inputs present at the rising edge.
    task automatic modelEdge();
        bit wasFull, wasEmpty;
        if (!rst_n) begin
            modelReset();
            return;
        end
        wasFull  = (q.size() == DEPTH);
        wasEmpty = (q.size() == 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        if (errClr) begin
            expOvf = 1'b0;
            expUnf = 1'b0;
        end else begin
            if (wr_en && wasFull  && !flush) expOvf = 1'b1;
            if (rd_en && wasEmpty && !flush) expUnf = 1'b1;
        end
`endif
        if (flush) begin
            q.delete();
            expRdValid = 1'b0;
        end else begin
            if (rd_en && !wasEmpty) begin
                expRdData  = q.pop_front();
                expRdValid = 1'b1;
            end else begin
                expRdValid = 1'b0;
            end
            if (wr_en && !wasFull) q.push_back(wr_data);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic idleInputs();
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        errClr = 1'b0;
`endif
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        idleInputs();
        rst_n = 1'b0;
        #1;
        modelReset();
        chkCnt++;
        if (obsStat0 !== 9'b0000_0_1_0_1_0 || rdData0 !== '0) begin
            errCnt++;
            $display("FAIL reset_reg: stat=%b data=%h, want stat=000001010 data=0", obsStat0, rdData0);
        end
        chkCnt++;
        if (obsStat1 !== 9'b0000_0_1_0_1_0) begin
            errCnt++;
            $display("FAIL reset_fwft: stat=%b, want 000001010", obsStat1);
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    // Write 1..8, one dropped write, then drain.
    task automatic test_fill_drain();
        for (int i = 1; i <= 9; i++) begin
            wr_en   = 1'b1;
            wr_data = (i == 9) ? 17'h1FFFF : DW'(i);
            cycle();
            chkCnt++;
            if (obsStat0 !== expStat0() || obsStat1 !== expStat1()) begin
                errCnt++;
                $display("FAIL fill_stat[%0d]: reg=%b fwft=%b, want reg=%b fwft=%b",
                         i, obsStat0, obsStat1, expStat0(), expStat1());
            end
            chkCnt++;
            if (af0 !== (i >= AFL)) begin
                errCnt++;
                $display("FAIL fill_afull[%0d]: got %b want %b", i, af0, (i >= AFL));
            end
        end
        wr_en = 1'b0;
        chkCnt++;
        if (full0 !== 1'b1 || count0 !== 4'd8) begin
            errCnt++;
            $display("FAIL fill_full: full=%b count=%0d, want full=1 count=8", full0, count0);
        end
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            cycle();
            chkCnt++;
            if (rdValid0 !== 1'b1 || rdData0 !== DW'(i)) begin
                errCnt++;
                $display("FAIL drain_data[%0d]: valid=%b data=%h, want valid=1 data=%h",
                         i, rdValid0, rdData0, DW'(i));
            end
            chkCnt++;
            if (obsStat0 !== expStat0() || obsStat1 !== expStat1() ||
                (q.size() != 0 && rdData1 !== expHead())) begin
                errCnt++;
                $display("FAIL drain_stat[%0d]: reg=%b fwft=%b head=%h, want reg=%b fwft=%b head=%h",
                         i, obsStat0, obsStat1, rdData1, expStat0(), expStat1(), expHead());
            end
        end
        rd_en = 1'b0;
        cycle();
        chkCnt++;
        if (rdValid0 !== 1'b0 || empty0 !== 1'b1 || rdData0 !== DW'(8)) begin
            errCnt++;
            $display("FAIL drain_end: valid=%b empty=%b data=%h, want 0 1 00008", rdValid0, empty0, rdData0);
        end
    endtask

    // Fill 5 then stream with concurrent read and write across pointer wrap.
    task automatic test_back_to_back();
        logic [DW-1:0] nextOut;
        nextOut = DW'(16'h100);
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(16'h100 + i);
            cycle();
        end
        rd_en = 1'b1;
        for (int i = 5; i < 25; i++) begin
            wr_data = DW'(16'h100 + i);
            cycle();
            chkCnt++;
            if (count0 !== 4'd5 || empty0 !== 1'b0 || full0 !== 1'b0 ||
                count1 !== 4'd5 || obsStat0 !== expStat0()) begin
                errCnt++;
                $display("FAIL b2b_stat[%0d]: count=%0d empty=%b full=%b, want 5 0 0",
                         i, count0, empty0, full0);
            end
            chkCnt++;
            if (rdData0 !== nextOut || rdData1 !== expHead()) begin
                errCnt++;
                $display("FAIL b2b_order[%0d]: reg=%h fwft=%h, want reg=%h fwft=%h",
                         i, rdData0, rdData1, nextOut, expHead());
            end
            nextOut = nextOut + 1'b1;
        end
        idleInputs();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    // Simultaneous read+write on a full and on an empty FIFO.
    task automatic test_full_empty_simul();
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(16'h200 + i);
            cycle();
        end
        wr_data = 17'h1ABCD;
        rd_en   = 1'b1;
        cycle();
        chkCnt++;
        if (count0 !== 4'd7 || rdValid0 !== 1'b1 || rdData0 !== DW'(16'h200) ||
            obsStat1 !== expStat1()) begin
            errCnt++;
            $display("FAIL full_rw: count=%0d valid=%b data=%h, want 7 1 00200", count0, rdValid0, rdData0);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 7; i++) cycle();
        chkCnt++;
        if (empty0 !== 1'b1 || rdData0 !== DW'(16'h207)) begin
            errCnt++;
            $display("FAIL full_rw_drain: empty=%b last=%h, want 1 00207", empty0, rdData0);
        end
        wr_en   = 1'b1;
        wr_data = 17'h0BEEF;
        cycle();
        chkCnt++;
        if (count0 !== 4'd1 || rdValid0 !== 1'b0 || rdValid1 !== 1'b1 || rdData1 !== 17'h0BEEF) begin
            errCnt++;
            $display("FAIL empty_rw: count=%0d valid=%b fwft_valid=%b fwft_data=%h, want 1 0 1 0beef",
                     count0, rdValid0, rdValid1, rdData1);
        end
        idleInputs();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic test_fwft();
        wr_en   = 1'b1;
        wr_data = 17'h0AAAA;
        cycle();
        wr_en = 1'b0;
        chkCnt++;
        if (rdValid1 !== 1'b1 || rdData1 !== 17'h0AAAA) begin
            errCnt++;
            $display("FAIL fwft_show: valid=%b data=%h, want 1 0aaaa", rdValid1, rdData1);
        end
        cycle();
        chkCnt++;
        if (rdValid1 !== 1'b1 || rdValid0 !== 1'b0) begin
            errCnt++;
            $display("FAIL fwft_hold: fwft_valid=%b reg_valid=%b, want 1 0", rdValid1, rdValid0);
        end
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        chkCnt++;
        if (empty1 !== 1'b1 || rdValid1 !== 1'b0 || rdData0 !== 17'h0AAAA) begin
            errCnt++;
            $display("FAIL fwft_pop: empty=%b valid=%b reg_data=%h, want 1 0 0aaaa", empty1, rdValid1, rdData0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(16'h300 + i);
            cycle();
        end
        rd_en = 1'b1;
        cycle();                          // reg side now holds 0x300, count 4
        rd_en = 1'b0;
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 17'h13579;
        cycle();
        idleInputs();
        chkCnt++;
        if (count0 !== '0 || empty0 !== 1'b1 || rdValid0 !== 1'b0 || rdData0 !== DW'(16'h300) ||
            count1 !== '0 || rdValid1 !== 1'b0) begin
            errCnt++;
            $display("FAIL flush: count=%0d empty=%b valid=%b data=%h, want 0 1 0 00300",
                     count0, empty0, rdValid0, rdData0);
        end
        cycle();
        chkCnt++;
        if (count0 !== '0 || obsStat0 !== expStat0()) begin
            errCnt++;
            $display("FAIL flush_discard: count=%0d, want 0", count0);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            rd_en   = (i >= 2);
            wr_data = DW'($urandom);
            cycle();
        end
        #2;
        rst_n = 1'b0;                     // mid-cycle, no edge follows before the check
        #1;
        chkCnt++;
        if (obsStat0 !== 9'b0000_0_1_0_1_0 || rdData0 !== '0 || obsStat1 !== 9'b0000_0_1_0_1_0) begin
            errCnt++;
            $display("FAIL async_reset: reg=%b data=%h fwft=%b, want 000001010 0 000001010",
                     obsStat0, rdData0, obsStat1);
        end
        modelReset();
        idleInputs();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_en   = ($urandom_range(0, 99) < 55);
            rd_en   = ($urandom_range(0, 99) < 45);
            flush   = ($urandom_range(0, 49) == 0);
            wr_data = DW'($urandom);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            errClr  = ($urandom_range(0, 29) == 0);
`endif
            cycle();
            chkCnt++;
            if (obsStat0 !== expStat0() || rdData0 !== expRdData) begin
                errCnt++;
                $display("FAIL rand_reg[%0d]: stat=%b data=%h, want stat=%b data=%h",
                         i, obsStat0, rdData0, expStat0(), expRdData);
            end
            chkCnt++;
            if (obsStat1 !== expStat1() || (q.size() != 0 && rdData1 !== expHead())) begin
                errCnt++;
                $display("FAIL rand_fwft[%0d]: stat=%b data=%h, want stat=%b data=%h",
                         i, obsStat1, rdData1, expStat1(), expHead());
            end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            chkCnt++;
            if (ovf0 !== expOvf || unf0 !== expUnf || ovf1 !== expOvf || unf1 !== expUnf) begin
                errCnt++;
                $display("FAIL rand_err[%0d]: ovf=%b unf=%b, want %b %b", i, ovf0, unf0, expOvf, expUnf);
            end
`endif
        end
        idleInputs();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    task automatic test_err_flags();
        errClr = 1'b1;
        cycle();
        errClr = 1'b0;
        rd_en  = 1'b1;                    // FIFO is empty here
        cycle();
        rd_en = 1'b0;
        cycle();
        chkCnt++;
        if (unf0 !== 1'b1 || ovf0 !== 1'b0) begin
            errCnt++;
            $display("FAIL err_underflow: unf=%b ovf=%b, want 1 0", unf0, ovf0);
        end
        for (int i = 0; i < 9; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(i);
            cycle();
        end
        chkCnt++;
        if (ovf0 !== 1'b1 || unf0 !== 1'b1) begin
            errCnt++;
            $display("FAIL err_overflow: ovf=%b unf=%b, want 1 1", ovf0, unf0);
        end
        flush = 1'b1;
        wr_en = 1'b0;
        cycle();
        flush = 1'b0;
        chkCnt++;
        if (ovf0 !== 1'b1 || unf0 !== 1'b1) begin
            errCnt++;
            $display("FAIL err_flush_keep: ovf=%b unf=%b, want 1 1", ovf0, unf0);
        end
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = DW'(i);
            cycle();
        end
        errClr = 1'b1;                    // clear collides with another overflow
        cycle();
        idleInputs();
        chkCnt++;
        if (ovf0 !== 1'b0 || unf0 !== 1'b0 || ovf1 !== 1'b0 || unf1 !== 1'b0) begin
            errCnt++;
            $display("FAIL err_clr_priority: ovf=%b unf=%b, want 0 0", ovf0, unf0);
        end
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_empty_simul();
        test_fwft();
        test_flush();
        test_async_reset();
        test_random();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("Simulation finished: %0d checks, %0d errors", chkCnt, errCnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Second-generation synchronous FIFO for the image-processing SoC peripheral fabric. It buffers pixel/command words between the bus side and the processing pipelines. Compared with the first generation it is generalised in width and depth and adds:
- an exact fill count
- programmable almost-full and almost-empty thresholds
- a synchronous flush
- a selectable first-word-fall-through (FWFT) read mode

Parameters:
DATA_WIDTH, 17, width of each stored word in bits.
ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH entries (legal range 1..12).
AFULL_LEVEL, 6, almost_full asserts when count >= AFULL_LEVEL (legal range 1..DEPTH).
AEMPTY_LEVEL, 1, almost_empty asserts when count <= AEMPTY_LEVEL (legal range 0..DEPTH-1).
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous reset, active low.
flush  in  1  synchronous clear of contents.
wr_en  in  1  write request.
wr_data  in  DATA_WIDTH  write word.
rd_en  in  1  read request (FWFT=1: pop/acknowledge of the head word).
rd_data  out  DATA_WIDTH  read word.
rd_valid  out  1  rd_data holds a valid word.
full  out  1  DEPTH entries stored.
empty  out  1  zero entries stored.
almost_full  out  1  count >= AFULL_LEVEL.
almost_empty  out  1  count <= AEMPTY_LEVEL.
count  out  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.

Behaviour:
- Single clock domain. rst_n is asynchronous assert, active low. Release of rst_n is synchronised externally.
- Storage: DEPTH x DATA_WIDTH array. The array is not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits, with the MSB used as the wrap bit.
  - full = (addresses equal) and (MSBs differ).
  - empty = pointers equal.
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
- Reset values:
  - pointers 0, count 0
  - empty 1, full 0, almost_empty 1
  - almost_full 0
  - rd_data 0, rd_valid 0
- Write accept: wr_acc = wr_en & ~full & ~flush. An accepted write stores wr_data at wr_ptr and increments wr_ptr.
- Write when full is dropped. Contents and pointers are unchanged. This holds even if a read is accepted in the same cycle.
- Read accept: rd_acc = rd_en & ~empty & ~flush. An accepted read increments rd_ptr.
- Read when empty is ignored. This holds even if a write is accepted in the same cycle; the written word becomes readable the next cycle.
- Simultaneous wr_acc and rd_acc: both pointers advance and count is unchanged.
- Flags: all status flags are combinational functions of the registered pointers. They update in the cycle after the accepting edge; they are never driven from the current-cycle rd_en/wr_en.
- FWFT=0 (registered read):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 on that edge. Latency is 1 cycle.
  - Otherwise rd_valid <= 0 and rd_data holds its previous value.
- FWFT=1:
  - rd_data = mem[rd_ptr] and rd_valid = ~empty, both combinational from registered state.
  - rd_en acts as the acknowledge. The next word appears the cycle after rd_acc.
  - rd_en while rd_valid=0 is ignored.
- Flush:
  - Synchronous. Takes priority over wr_en and rd_en in the same cycle.
  - Next cycle: both pointers are 0, count 0, empty 1, rd_valid 0.
  - rd_data is not cleared.
- Wrap-around: pointers wrap naturally modulo 2**(ADDR_WIDTH+1). No special casing is required.
- Reset mid-operation: all state returns to reset values immediately. Contents are lost.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- When defined, the block adds these ports:
  - overflow (out, 1): sticky; set on the edge after wr_en & full & ~flush.
  - underflow (out, 1): sticky; set on the edge after rd_en & empty & ~flush.
  - err_clr (in, 1): synchronous clear of both flags. err_clr has priority over a simultaneous set.
- overflow and underflow reset to 0. flush does not clear them.
- When not defined, these ports and their logic do not exist. Dropped requests are silent.

Test Plan:
- Defaults (DEPTH 8, FWFT=0), write 8 words 0x00001..0x00008 -> full=1 and count=8 after the 8th edge; almost_full=1 from count=6. A 9th write with 0x1FFFF is dropped; reading 8 words returns 1..8, each with rd_valid=1 exactly one cycle after rd_en.
- Fill 5 words, then hold wr_en and rd_en together for 20 cycles with incrementing data -> count stays 5. Output order is strictly incrementing across pointer wrap; empty and full both stay 0.
- Full FIFO with wr_en=1, rd_en=1 for one cycle -> write dropped, one read returned, count 8->7. Empty FIFO with wr_en=1, rd_en=1 -> read ignored, rd_valid=0, count 0->1.
- FWFT=1: write 0x0AAAA into an empty FIFO -> rd_valid=1 and rd_data=0x0AAAA on the next cycle with no rd_en. Pulsing rd_en -> empty=1 and rd_valid=0 next cycle.
- Count=4, assert flush together with wr_en -> next cycle count=0 and empty=1, write discarded. Assert rst_n=0 mid-burst -> all outputs at reset values without a clock edge.
- SYNC_FIFO_ERR_FLAGS_EN defined: read when empty -> underflow=1 and held. Write when full -> overflow=1. err_clr together with a new overflow event -> both flags 0 next cycle.
